// File: rtl/cpu_run_ctrl.sv
// Run controller for the MIPS CPU harness.
// Sequences a CPU reset pulse, counts run cycles and detects program end by
// explicit halt, PC self-loop or cycle-budget timeout.
module cpu_run_ctrl #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 4,     // >= 1
  parameter int STALL_LIMIT  = 3,     // >= 2
  parameter int MAX_CYCLES   = 1000   // 0 disables the timeout
) (
  input  logic             clk,
  input  logic             reset,     // synchronous, active-low
  input  logic             start,
  input  logic             halt_in,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int RST_W   = $clog2(RESET_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  // Last RST cycle index, and the stall count that, combined with one more
  // equal sample, makes STALL_LIMIT consecutive equal samples.
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 2);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam bit                 BUDGET_ON  = (MAX_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic               pc_valid_q, pc_valid_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  logic pc_same;
  logic hit_stall;
  logic hit_budget;

  // Exit condition decode from current inputs and pre-edge counters.
  always_comb begin
    pc_same    = pc_valid_q && (pc == last_pc_q);
    hit_stall  = pc_same && (stall_cnt_q == STALL_LAST);
    hit_budget = BUDGET_ON && (cycle_cnt_q == CNT_LAST);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    last_pc_d   = last_pc_q;
    pc_valid_d  = pc_valid_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d     = S_RST;
          rst_cnt_d   = '0;
          stall_cnt_d = '0;
          pc_valid_d  = 1'b0;
          cycle_cnt_d = '0;
        end
      end
      S_RST: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        last_pc_d   = pc;
        pc_valid_d  = 1'b1;
        stall_cnt_d = pc_same ? stall_cnt_q + 1'b1 : '0;
        // Halt and self-loop outrank the budget when they coincide.
        if (halt_in || hit_stall) begin
          state_d = S_DONE;
        end else if (hit_budget) begin
          state_d = S_TIMEOUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are a registered decode of the next state, so they change on
    // the same edge as the state itself.
    cpu_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    timeout_d   = (state_d == S_TIMEOUT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      stall_cnt_q <= '0;
      last_pc_q   <= '0;
      pc_valid_q  <= 1'b0;
      cycle_cnt_q <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      last_pc_q   <= last_pc_d;
      pc_valid_q  <= pc_valid_d;
      cycle_cnt_q <= cycle_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: expected end-of-run results are
// queued when a run is launched and checked when done/timeout rises.
module tb_cpu_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;
  localparam int RC    = 4;
  localparam int SL    = 3;
  localparam int MC    = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset   = 1'b0;
  logic             start   = 1'b0;
  logic             halt_in = 1'b0;
  logic [PC_W-1:0]  pc      = '0;

  logic             cpu_reset, running, done, timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic             nt_cpu_reset, nt_running, nt_done, nt_timeout;
  logic [CNT_W-1:0] nt_cycle_cnt;

  cpu_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RESET_CYCLES(RC), .STALL_LIMIT(SL), .MAX_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_in(halt_in), .pc(pc),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  // Same controller with the timeout disabled.
  cpu_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RESET_CYCLES(RC), .STALL_LIMIT(SL), .MAX_CYCLES(0)
  ) dut_nt (
    .clk(clk), .reset(reset), .start(start), .halt_in(halt_in), .pc(pc),
    .cpu_reset(nt_cpu_reset), .running(nt_running), .done(nt_done), .timeout(nt_timeout),
    .cycle_cnt(nt_cycle_cnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string            tag;
    logic             is_to;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic end_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_end(input string tag, input logic is_to, input int cnt);
    exp_t e;
    e.tag   = tag;
    e.is_to = is_to;
    e.cnt   = CNT_W'(cnt);
    sb.push_back(e);
    $display("queue %s is_to=%0d cnt=%0d", tag, is_to, cnt);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_running"},   running,   0);
    check({tag, "_done"},      done,      0);
    check({tag, "_timeout"},   timeout,   0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
  endtask

  // One-edge start pulse, then verify the cpu_reset pulse length.
  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_st_cpu_reset"}, cpu_reset, 1);
    check({tag, "_st_running"},   running,   0);
    check({tag, "_st_done"},      done,      0);
    check({tag, "_st_timeout"},   timeout,   0);
    check({tag, "_st_cycle_cnt"}, cycle_cnt, 0);
    for (int j = 1; j < RC; j++) begin
      tick();
      check({tag, "_pulse_cpu_reset"}, cpu_reset, 1);
      check({tag, "_pulse_running"},   running,   0);
    end
    tick();
    check({tag, "_run_cpu_reset"}, cpu_reset, 0);
    check({tag, "_run_running"},   running,   1);
    check({tag, "_run_cycle_cnt"}, cycle_cnt, 0);
    $display("start %s: reset pulse %0d cycles", tag, RC);
  endtask

  // n RUN edges with PC stepping by 4; halt_in asserted on edge index halt_at.
  task automatic run_inc(input int n, input int halt_at);
    for (int i = 0; i < n; i++) begin
      pc      = 32'h1000 + 32'(4 * i);
      halt_in = (i == halt_at);
      tick();
    end
    halt_in = 1'b0;
  endtask

  // Scoreboard consumer: compare each run end against the queued expectation.
  always @(negedge clk) begin
    if (((done | timeout) === 1'b1) && !end_prev) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_end", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_done"},      done,      !mon_e.is_to);
        check({mon_e.tag, "_timeout"},   timeout,   mon_e.is_to);
        check({mon_e.tag, "_cycle_cnt"}, cycle_cnt, mon_e.cnt);
        check({mon_e.tag, "_running"},   running,   0);
        check({mon_e.tag, "_cpu_reset"}, cpu_reset, 0);
        $display("end %s: done=%0d timeout=%0d cycle_cnt=%0d", mon_e.tag, done, timeout, cycle_cnt);
      end
    end
    end_prev <= ((done | timeout) === 1'b1);
  end

  logic [PC_W-1:0] seq5 [5];
  logic [PC_W-1:0] seq6 [6];

  initial begin
    seq5 = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008};
    seq6 = '{32'h3000, 32'h3004, 32'h3004, 32'h3008, 32'h3008, 32'h3008};

    // Reset held for three edges, then released with start low.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rst");
    end
    reset = 1'b1;
    tick();
    check_idle("idle");
    tick();
    check_idle("idle2");
    $display("reset/idle phase complete");

    // Self-loop halt after three equal samples.
    do_start("loop5");
    expect_end("loop5", 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      pc = seq5[i];
      tick();
      if (i == 3) begin
        check("loop5_pre_done", done, 0);
        check("loop5_pre_cnt", cycle_cnt, 4);
      end
    end

    // A PC held for only two samples does not end the run.
    do_start("loop6");
    expect_end("loop6", 1'b0, 6);
    for (int i = 0; i < 6; i++) begin
      pc = seq6[i];
      tick();
      if (i == 2) check("loop6_two_equal_running", running, 1);
      if (i == 4) check("loop6_pre_done", done, 0);
    end

    // Halt on the same edge the budget would expire: halt wins.
    do_start("prio");
    expect_end("prio", 1'b0, MC);
    run_inc(MC - 1, -1);
    check("prio_pre_running", running, 1);
    check("prio_pre_cnt", cycle_cnt, MC - 1);
    run_inc(1, 0);
    check("prio_timeout_clear", timeout, 0);

    // Restart from DONE, then reset in the middle of the run.
    do_start("restart");
    run_inc(20, -1);
    check("mid_cnt", cycle_cnt, 20);
    check("mid_running", running, 1);
    reset = 1'b0;
    tick();
    check_idle("midrst");
    reset = 1'b1;
    tick();
    check_idle("midrst_rel");
    $display("mid-run reset phase complete");

    // Budget exhaustion; the unlimited instance keeps running.
    do_start("tmo");
    expect_end("tmo", 1'b1, MC);
    run_inc(10100, -1);
    check("tmo_frozen_cnt", cycle_cnt, MC);
    check("tmo_frozen_flag", timeout, 1);
    check("tmo_done_clear", done, 0);
    check("nolimit_timeout", nt_timeout, 0);
    check("nolimit_running", nt_running, 1);
    check("nolimit_cnt", nt_cycle_cnt, 10100);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
